// File: rtl/cpu_isa_pkg.sv
// ISA definitions shared by the decode/issue stage: opcodes, field positions,
// the decoded-field record and small classification helpers.
package cpu_isa_pkg;

    localparam int INSTR_W = 32;

    // Legal opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LUI   = 6'b010101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Field bit positions inside the instruction word
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Fields as the ALU consumes them
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } decoded_t;

    localparam int DECODED_W = $bits(decoded_t);

    // Load-use hazard sequencer states
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } hz_state_e;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI,
            OP_BEQ, OP_BNE, OP_LW, OP_SW: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // Opcodes that read rt as a source operand (rather than writing it)
    function automatic logic uses_rt_as_source(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

    // Split a raw word; rd/shamt/funct only carry meaning for R-type
    function automatic decoded_t decode_instr(input logic [INSTR_W-1:0] instr);
        decoded_t d;
        d        = '0;
        d.opcode = instr[OPCODE_MSB:OPCODE_LSB];
        d.rs     = instr[RS_MSB:RS_LSB];
        d.rt     = instr[RT_MSB:RT_LSB];
        d.imm    = instr[IMM_MSB:IMM_LSB];
        if (d.opcode == OP_RTYPE) begin
            d.rd    = instr[RD_MSB:RD_LSB];
            d.shamt = instr[SHAMT_MSB:SHAMT_LSB];
            d.funct = instr[FUNCT_MSB:FUNCT_LSB];
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-entry head/skid register pair with valid/ready on both sides.
// The head register drives the consumer; the skid register absorbs one
// extra word while the head is stalled. Order is always preserved.
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         head_v_q, head_v_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] skid_q, skid_d;
    logic         push;
    logic         pop;

    assign in_ready  = !skid_v_q;
    assign out_valid = head_v_q;
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = head_v_q && out_ready;

    // Next-state: refill head from skid on a pop, otherwise land new words in the first free slot
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        head_d   = head_q;
        skid_d   = skid_q;
        if (pop) begin
            if (skid_v_q) begin
                head_d = skid_q;
                if (push) begin
                    skid_d = in_data;
                end else begin
                    skid_v_d = 1'b0;
                end
            end else if (push) begin
                head_d = in_data;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (push) begin
            if (!head_v_q) begin
                head_v_d = 1'b1;
                head_d   = in_data;
            end else begin
                skid_v_d = 1'b1;
                skid_d   = in_data;
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            // NOTE: payload registers are cleared too, because the field outputs must read 0 after reset.
            head_q   <= '0;
            skid_q   <= '0;
        end else begin
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            head_q   <= head_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/instr_decode_issue.sv
// Decode/issue stage in front of the ALU. Splits instructions into ALU
// fields, buffers them in a head/skid pair, inserts one bubble on a
// load-use dependency, drops illegal opcodes and counts issued words.
module instr_decode_issue
    import cpu_isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         opcode,
    output logic [4:0]         rs_addr,
    output logic [4:0]         rt_addr,
    output logic [4:0]         rd_addr,
    output logic [4:0]         shamt,
    output logic [5:0]         ALU_control,
    output logic [15:0]        immediate,
    output logic               illegal,
    output logic [CNT_W-1:0]   issue_count
);

    decoded_t       in_dec;
    decoded_t       head;
    logic           in_legal;
    logic           accept;
    logic           buf_in_valid;
    logic           buf_in_ready;
    logic           head_valid;
    logic           buf_out_ready;
    logic           transfer;
    logic           hazard;

    hz_state_e      state_q, state_d;
    logic           lw_pend_q, lw_pend_d;
    logic [4:0]     lw_rt_q, lw_rt_d;
    logic           illegal_q, illegal_d;
    logic [CNT_W-1:0] issue_count_q, issue_count_d;

    // Input side: illegal words complete the handshake but never enter the buffer
    assign in_dec       = decode_instr(instr);
    assign in_legal     = is_legal_opcode(in_dec.opcode);
    assign in_ready     = buf_in_ready && !rst;
    assign accept       = in_valid && in_ready;
    assign buf_in_valid = accept && in_legal;

    decode_skid_buf #(
        .W (DECODED_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (buf_in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (in_dec),
        .out_valid (head_valid),
        .out_ready (buf_out_ready),
        .out_data  (head)
    );

    // Load-use detection against the instruction waiting in the head slot
    always_comb begin
        hazard = 1'b0;
        if (state_q == ST_RUN && head_valid && lw_pend_q && lw_rt_q != 5'd0) begin
            if (head.opcode != OP_LUI && head.rs == lw_rt_q) begin
                hazard = 1'b1;
            end
            if (uses_rt_as_source(head.opcode) && head.rt == lw_rt_q) begin
                hazard = 1'b1;
            end
        end
    end

    // Hazard FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Hazard FSM next state: a detected hazard costs exactly one BUBBLE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (hazard) state_d = ST_BUBBLE;
            ST_BUBBLE: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Hazard FSM outputs: hide the head and block its pop during the bubble
    always_comb begin
        out_valid     = head_valid && !hazard;
        buf_out_ready = out_ready && !hazard;
        transfer      = out_valid && out_ready;
    end

    // Load record, illegal pulse and issue counter next state
    always_comb begin
        lw_pend_d     = lw_pend_q;
        lw_rt_d       = lw_rt_q;
        illegal_d     = accept && !in_legal;
        issue_count_d = issue_count_q;
        if (transfer) begin
            lw_pend_d     = (head.opcode == OP_LW);
            issue_count_d = issue_count_q + CNT_W'(1);
            if (head.opcode == OP_LW) begin
                lw_rt_d = head.rt;
            end
        end else if (hazard) begin
            lw_pend_d = 1'b0;
        end
    end

    // Load record, illegal pulse and issue counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lw_pend_q     <= 1'b0;
            lw_rt_q       <= '0;
            illegal_q     <= 1'b0;
            issue_count_q <= '0;
        end else begin
            lw_pend_q     <= lw_pend_d;
            lw_rt_q       <= lw_rt_d;
            illegal_q     <= illegal_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign opcode      = head.opcode;
    assign rs_addr     = head.rs;
    assign rt_addr     = head.rt;
    assign rd_addr     = head.rd;
    assign shamt       = head.shamt;
    assign ALU_control = head.funct;
    assign immediate   = head.imm;
    assign illegal     = illegal_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_instr_decode_issue.sv
// Directed bench for instr_decode_issue. Inputs change on the falling edge,
// outputs are sampled on the falling edge, the DUT registers on the rising edge.
module tb_instr_decode_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [5:0]  ALU_control;
    logic [15:0] immediate;
    logic        illegal;
    logic [15:0] issue_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_decode_issue #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rd_addr     (rd_addr),
        .shamt       (shamt),
        .ALU_control (ALU_control),
        .immediate   (immediate),
        .illegal     (illegal),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready_low: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", issue_count); end
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal: got %b expected 0", illegal); end
        n_checks++; if ({opcode, rs_addr, rt_addr, rd_addr, shamt, ALU_control, immediate} !== 48'd0) begin
            n_fail++; $display("FAIL rst_fields: got %h expected 0", {opcode, rs_addr, rt_addr, rd_addr, shamt, ALU_control, immediate}); end
        rst = 1'b0;
        cyc();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready_after: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_lui();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h5400_0007;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lui_not_early: got %b expected 0", out_valid); end
        cyc();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lui_valid: got %b expected 1", out_valid); end
        n_checks++; if (opcode !== 6'b010101) begin n_fail++; $display("FAIL lui_opcode: got %b expected 010101", opcode); end
        n_checks++; if (immediate !== 16'h0007) begin n_fail++; $display("FAIL lui_imm: got %h expected 0007", immediate); end
        n_checks++; if (ALU_control !== 6'd0) begin n_fail++; $display("FAIL lui_alu_ctl: got %b expected 0", ALU_control); end
        n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL lui_rd: got %0d expected 0", rd_addr); end
        cyc();
        n_checks++; if (issue_count !== 16'd1) begin n_fail++; $display("FAIL lui_count: got %0d expected 1", issue_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lui_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_rtype();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0128_5020;
        cyc();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rt_valid: got %b expected 1", out_valid); end
        n_checks++; if (opcode !== 6'd0) begin n_fail++; $display("FAIL rt_opcode: got %b expected 0", opcode); end
        n_checks++; if (rs_addr !== 5'd9) begin n_fail++; $display("FAIL rt_rs: got %0d expected 9", rs_addr); end
        n_checks++; if (rt_addr !== 5'd8) begin n_fail++; $display("FAIL rt_rt: got %0d expected 8", rt_addr); end
        n_checks++; if (rd_addr !== 5'd10) begin n_fail++; $display("FAIL rt_rd: got %0d expected 10", rd_addr); end
        n_checks++; if (ALU_control !== 6'b100000) begin n_fail++; $display("FAIL rt_alu_ctl: got %b expected 100000", ALU_control); end
        n_checks++; if (shamt !== 5'd0) begin n_fail++; $display("FAIL rt_shamt: got %0d expected 0", shamt); end
        n_checks++; if (immediate !== 16'h5020) begin n_fail++; $display("FAIL rt_imm: got %h expected 5020", immediate); end
        cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h2000_0001;
        cyc();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_1: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0001) begin n_fail++; $display("FAIL b2b_head_a: got v=%b imm=%h expected v=1 imm=0001", out_valid, immediate); end
        instr = 32'h2000_0002;
        cyc();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b expected 0", in_ready); end
        n_checks++; if (immediate !== 16'h0001) begin n_fail++; $display("FAIL b2b_hold_1: got %h expected 0001", immediate); end
        instr = 32'h2000_0003;
        cyc();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_still_full: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0001 || opcode !== 6'b001000) begin
            n_fail++; $display("FAIL b2b_hold_2: got v=%b op=%b imm=%h expected v=1 op=001000 imm=0001", out_valid, opcode, immediate); end
        n_checks++; if (issue_count !== 16'd0) begin n_fail++; $display("FAIL b2b_count_stalled: got %0d expected 0", issue_count); end
        out_ready = 1'b1;
        cyc();
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0002) begin n_fail++; $display("FAIL b2b_second: got v=%b imm=%h expected v=1 imm=0002", out_valid, immediate); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_reopen: got %b expected 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0003) begin n_fail++; $display("FAIL b2b_third: got v=%b imm=%h expected v=1 imm=0003", out_valid, immediate); end
        cyc();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
        n_checks++; if (issue_count !== 16'd3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", issue_count); end
    endtask

    task automatic test_load_use();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h8C05_0000;
        cyc();
        n_checks++; if (out_valid !== 1'b1 || opcode !== 6'b100011 || rt_addr !== 5'd5) begin
            n_fail++; $display("FAIL lu_lw: got v=%b op=%b rt=%0d expected v=1 op=100011 rt=5", out_valid, opcode, rt_addr); end
        instr = 32'h00A6_3820;
        cyc();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble: got %b expected 0", out_valid); end
        n_checks++; if (issue_count !== 16'd1) begin n_fail++; $display("FAIL lu_count_bubble: got %0d expected 1", issue_count); end
        cyc();
        n_checks++; if (out_valid !== 1'b1 || opcode !== 6'd0 || rs_addr !== 5'd5 || rd_addr !== 5'd7) begin
            n_fail++; $display("FAIL lu_add: got v=%b op=%b rs=%0d rd=%0d expected v=1 op=0 rs=5 rd=7", out_valid, opcode, rs_addr, rd_addr); end
        cyc();
        n_checks++; if (out_valid !== 1'b0 || issue_count !== 16'd2) begin
            n_fail++; $display("FAIL lu_done: got v=%b cnt=%0d expected v=0 cnt=2", out_valid, issue_count); end
    endtask

    task automatic test_no_hazard();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h8C05_0000;
        cyc();
        instr = 32'h3060_00FF;
        cyc();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || opcode !== 6'b001100 || rs_addr !== 5'd3) begin
            n_fail++; $display("FAIL nh_andi: got v=%b op=%b rs=%0d expected v=1 op=001100 rs=3", out_valid, opcode, rs_addr); end
        cyc();
        n_checks++; if (out_valid !== 1'b0 || issue_count !== 16'd2) begin
            n_fail++; $display("FAIL nh_done: got v=%b cnt=%0d expected v=0 cnt=2", out_valid, issue_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h2000_0011;
        cyc();
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0011 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL il_first: got v=%b imm=%h ill=%b expected v=1 imm=0011 ill=0", out_valid, immediate, illegal); end
        instr = 32'hFC00_0000;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL il_ready: got %b expected 1", in_ready); end
        cyc();
        n_checks++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL il_pulse: got %b expected 1", illegal); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL il_not_enqueued: got %b expected 0", out_valid); end
        instr = 32'h2000_0022;
        cyc();
        in_valid = 1'b0;
        n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL il_pulse_end: got %b expected 0", illegal); end
        n_checks++; if (out_valid !== 1'b1 || immediate !== 16'h0022) begin
            n_fail++; $display("FAIL il_second: got v=%b imm=%h expected v=1 imm=0022", out_valid, immediate); end
        cyc();
        n_checks++; if (issue_count !== 16'd2 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL il_count: got cnt=%0d ill=%b expected cnt=2 ill=0", issue_count, illegal); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h2000_0044;
        cyc();
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h2000_0055;
        cyc();
        instr = 32'h2000_0066;
        cyc();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || issue_count !== 16'd1) begin
            n_fail++; $display("FAIL rm_full: got rdy=%b v=%b cnt=%0d expected rdy=0 v=1 cnt=1", in_ready, out_valid, issue_count); end
        rst = 1'b1; in_valid = 1'b0;
        cyc();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_in_reset: got rdy=%b v=%b expected rdy=0 v=0", in_ready, out_valid); end
        rst = 1'b0;
        cyc();
        n_checks++; if (out_valid !== 1'b0 || issue_count !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_after: got v=%b cnt=%0d rdy=%b expected v=0 cnt=0 rdy=1", out_valid, issue_count, in_ready); end
        n_checks++; if (immediate !== 16'd0 || opcode !== 6'd0) begin
            n_fail++; $display("FAIL rm_fields: got op=%b imm=%h expected 0", opcode, immediate); end
        out_ready = 1'b1;
        cyc();
        cyc();
        n_checks++; if (issue_count !== 16'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rm_discarded: got cnt=%0d v=%b expected cnt=0 v=0", issue_count, out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        test_reset();
        test_lui();
        test_rtype();
        test_back_to_back();
        test_load_use();
        test_no_hazard();
        test_illegal();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
